// File: rtl/pl1_pkg.sv
// Shared types and constants for the PL1 trigger acceptance block.
package pl1_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StQual,
    StDead
  } state_e;

  localparam int unsigned TS_W_DEF = 32;
  localparam logic [15:0] CNT_SAT = 16'hFFFF;

  // Record layout at the default timestamp width; the FIFO stores {evnum, tstamp} flat.
  typedef struct packed {
    logic [15:0]         evnum;
    logic [TS_W_DEF-1:0] tstamp;
  } trig_rec_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == CNT_SAT) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/trig_rec_fifo.sv
// Synchronous record FIFO with a registered head entry; full/empty come from a registered count.
module trig_rec_fifo #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DATA_W     = 48
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
  logic [CW-1:0]     cnt_q, cnt_after_pop, cnt_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic              push_en, pop_en;

  assign full    = (cnt_q == CW'(FIFO_DEPTH));
  assign empty   = (cnt_q == '0);
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign head    = head_q;

  always_comb begin
    rd_ptr_nxt    = rd_ptr_q + AW'(pop_en);
    cnt_after_pop = cnt_q - CW'(pop_en);
    cnt_d         = cnt_after_pop + CW'(push_en);
    head_d        = head_q;
    // With nothing older left, the head is whatever gets pushed this cycle.
    if (cnt_after_pop == '0) begin
      if (push_en) head_d = push_data;
    end else begin
      head_d = mem_q[rd_ptr_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      head_q   <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      rd_ptr_q <= rd_ptr_nxt;
      cnt_q    <= cnt_d;
      head_q   <= head_d;
    end
  end

endmodule

// File: rtl/pl1_trig_accept.sv
// PL1 trigger acceptance: width qualification, veto, deadtime, event tagging and
// record buffering toward readout, with saturating run statistics.
module pl1_trig_accept
  import pl1_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TS_W       = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ena,
  input  logic            clr,
  input  logic            trig_in,
  input  logic            veto,
  input  logic [3:0]      min_width,
  input  logic [15:0]     deadtime,
  output logic            out_valid,
  output logic [15:0]     out_evnum,
  output logic [TS_W-1:0] out_tstamp,
  input  logic            out_ready,
  output logic            busy,
  output logic [15:0]     n_raw,
  output logic [15:0]     n_vetoed,
  output logic [15:0]     n_dropped
);

  state_e          state_q, state_d;
  logic            prev_q;
  logic [TS_W-1:0] ts_q, ts_edge_q, ts_edge_d, rec_ts;
  logic [3:0]      hcnt_q, hcnt_d, mw_eff;
  logic [15:0]     dcnt_q, dcnt_d;
  logic [15:0]     evnum_q, n_raw_q, n_vetoed_q, n_dropped_q;
  logic            edge_det, qual, push, full, empty;
  logic [16+TS_W-1:0] head;

  assign edge_det = trig_in && !prev_q;
  assign mw_eff   = (min_width == 4'd0) ? 4'd1 : min_width;

  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    dcnt_d    = dcnt_q;
    ts_edge_d = ts_edge_q;
    rec_ts    = ts_edge_q;
    qual      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (edge_det) begin
          ts_edge_d = ts_q;
          rec_ts    = ts_q;
          hcnt_d    = 4'd1;
          if (mw_eff == 4'd1) qual = 1'b1;
          else                state_d = StQual;
        end
      end
      StQual: begin
        if (!trig_in) begin
          state_d = StIdle;
        end else begin
          hcnt_d = hcnt_q + 4'd1;
          if (hcnt_d == mw_eff) qual = 1'b1;
        end
      end
      StDead: begin
        if (dcnt_q == 16'd0) state_d = StIdle;
        else                 dcnt_d  = dcnt_q - 16'd1;
      end
      default: state_d = StIdle;
    endcase
    if (qual) begin
      if (veto) begin
        state_d = StIdle;
      end else begin
        state_d = StDead;
        dcnt_d  = deadtime;
      end
    end
    if (!ena) begin
      state_d = StIdle;
      hcnt_d  = 4'd0;
      dcnt_d  = 16'd0;
      qual    = 1'b0;
    end
  end

  // Full is sampled before this cycle's pop, so a full FIFO always drops.
  assign push = qual && !veto && !full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      prev_q    <= 1'b0;
      ts_q      <= '0;
      ts_edge_q <= '0;
      hcnt_q    <= 4'd0;
      dcnt_q    <= 16'd0;
    end else begin
      state_q   <= state_d;
      prev_q    <= trig_in;
      ts_edge_q <= ts_edge_d;
      hcnt_q    <= hcnt_d;
      dcnt_q    <= dcnt_d;
      if (ena) ts_q <= ts_q + TS_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      evnum_q     <= 16'd0;
      n_raw_q     <= 16'd0;
      n_vetoed_q  <= 16'd0;
      n_dropped_q <= 16'd0;
    end else if (clr) begin
      evnum_q     <= 16'd0;
      n_raw_q     <= 16'd0;
      n_vetoed_q  <= 16'd0;
      n_dropped_q <= 16'd0;
    end else begin
      if (push)                n_raw_q     <= n_raw_q;
      if (push)                evnum_q     <= evnum_q + 16'd1;
      if (qual)                n_raw_q     <= sat_inc(n_raw_q);
      if (qual && veto)        n_vetoed_q  <= sat_inc(n_vetoed_q);
      if (qual && !veto && full) n_dropped_q <= sat_inc(n_dropped_q);
    end
  end

  trig_rec_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DATA_W     (16 + TS_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({evnum_q, rec_ts}),
    .pop       (out_ready),
    .full      (full),
    .empty     (empty),
    .head      (head)
  );

  assign out_valid  = !empty;
  assign out_evnum  = head[16+TS_W-1:TS_W];
  assign out_tstamp = head[TS_W-1:0];
  assign busy       = (state_q != StIdle) || full;
  assign n_raw      = n_raw_q;
  assign n_vetoed   = n_vetoed_q;
  assign n_dropped  = n_dropped_q;

endmodule

// File: tb/tb_pl1_trig_accept.sv
// Directed bench for pl1_trig_accept: a pulse-shape vector table plus hand-written
// sequences for deadtime, FIFO overflow, sustained level and mid-run reset.
module tb_pl1_trig_accept;

  logic        clk, rst, ena, clr, trig_in, veto, out_ready;
  logic [3:0]  min_width;
  logic [15:0] deadtime;
  logic        out_valid, busy;
  logic [15:0] out_evnum, n_raw, n_vetoed, n_dropped;
  logic [31:0] out_tstamp;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;  // equals the DUT timestamp while ena stays high

  pl1_trig_accept #(
    .FIFO_DEPTH (4),
    .TS_W       (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .clr        (clr),
    .trig_in    (trig_in),
    .veto       (veto),
    .min_width  (min_width),
    .deadtime   (deadtime),
    .out_valid  (out_valid),
    .out_evnum  (out_evnum),
    .out_tstamp (out_tstamp),
    .out_ready  (out_ready),
    .busy       (busy),
    .n_raw      (n_raw),
    .n_vetoed   (n_vetoed),
    .n_dropped  (n_dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] mw;
    int         width;
    bit         veto_q;
    int         q;       // qualification cycle offset from the edge
    bit         rec;
    int         raw;
    int         vetoed;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      cyc++;
    end
    #1;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step(1);
    clr = 1'b0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
  endtask

  int e, e2;
  int ev[5];

  initial begin
    vecs[0] = '{"mw4_w9",   4'd4,  9,  1'b0, 3,  1'b1, 1, 0};
    vecs[1] = '{"mw4_w3",   4'd4,  3,  1'b0, 3,  1'b0, 0, 0};
    vecs[2] = '{"mw0_w1",   4'd0,  1,  1'b0, 0,  1'b1, 1, 0};
    vecs[3] = '{"mw1_w2",   4'd1,  2,  1'b0, 0,  1'b1, 1, 0};
    vecs[4] = '{"mw4_w4",   4'd4,  4,  1'b0, 3,  1'b1, 1, 0};
    vecs[5] = '{"mw4_veto", 4'd4,  9,  1'b1, 3,  1'b0, 1, 1};
    vecs[6] = '{"mw15_w15", 4'd15, 15, 1'b0, 14, 1'b1, 1, 0};
    vecs[7] = '{"mw15_w14", 4'd15, 14, 1'b0, 14, 1'b0, 0, 0};

    rst = 1'b0; ena = 1'b0; clr = 1'b0; trig_in = 1'b0; veto = 1'b0; out_ready = 1'b0;
    min_width = 4'd4; deadtime = 16'd20;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_evnum", 64'(out_evnum), 64'd0);
    chk("rst_tstamp", 64'(out_tstamp), 64'd0);
    chk("rst_cnts", {16'd0, n_raw, n_vetoed, n_dropped}, 64'd0);

    // Pulse rising at ts=100, min_width=4, deadtime=20.
    ena = 1'b1;
    cyc = 0;
    step(100);
    trig_in = 1'b1;
    step(3);
    chk("a_valid_q", 64'(out_valid), 64'd0);
    step(1);
    chk("a_valid_q1", 64'(out_valid), 64'd1);
    chk("a_evnum", 64'(out_evnum), 64'd0);
    chk("a_tstamp", 64'(out_tstamp), 64'd100);
    chk("a_raw", 64'(n_raw), 64'd1);
    chk("a_busy", 64'(busy), 64'd1);
    step(5);
    trig_in = 1'b0;
    pop_one();
    chk("a_popped", 64'(out_valid), 64'd0);
    step(20);
    chk("a_idle", 64'(busy), 64'd0);

    // Pulse-shape table, deadtime 4.
    for (int v = 0; v < 8; v++) begin
      do_clr();
      min_width = vecs[v].mw;
      deadtime  = 16'd4;
      e = cyc;
      for (int i = 0; i < 24; i++) begin
        if (i == vecs[v].q) chk({vecs[v].name, "_pre"}, 64'(out_valid), 64'd0);
        if (i == vecs[v].q + 1) chk({vecs[v].name, "_valid"}, 64'(out_valid), 64'(vecs[v].rec));
        trig_in = (i < vecs[v].width);
        veto    = vecs[v].veto_q && (i == vecs[v].q);
        step(1);
      end
      chk({vecs[v].name, "_raw"}, 64'(n_raw), 64'(vecs[v].raw));
      chk({vecs[v].name, "_veto"}, 64'(n_vetoed), 64'(vecs[v].vetoed));
      chk({vecs[v].name, "_drop"}, 64'(n_dropped), 64'd0);
      chk({vecs[v].name, "_busy"}, 64'(busy), 64'd0);
      if (vecs[v].rec) begin
        chk({vecs[v].name, "_evnum"}, 64'(out_evnum), 64'd0);
        chk({vecs[v].name, "_ts"}, 64'(out_tstamp), 64'(e));
        pop_one();
        chk({vecs[v].name, "_empty"}, 64'(out_valid), 64'd0);
      end
    end

    // Veto, then a new pulse two cycles after the first falls.
    do_clr();
    min_width = 4'd4; deadtime = 16'd20;
    trig_in = 1'b1;
    step(3);
    veto = 1'b1;
    step(1);
    veto = 1'b0;
    chk("v_vetoed", 64'(n_vetoed), 64'd1);
    chk("v_norec", 64'(out_valid), 64'd0);
    chk("v_idle", 64'(busy), 64'd0);
    step(5);
    trig_in = 1'b0;
    step(2);
    trig_in = 1'b1;
    e2 = cyc;
    step(4);
    chk("v2_valid", 64'(out_valid), 64'd1);
    chk("v2_evnum", 64'(out_evnum), 64'd0);
    chk("v2_ts", 64'(out_tstamp), 64'(e2));
    chk("v2_raw", 64'(n_raw), 64'd2);
    step(5);
    trig_in = 1'b0;
    pop_one();
    step(20);

    // Five pulses with readout stalled: four buffered, one dropped.
    do_clr();
    for (int k = 0; k < 5; k++) begin
      ev[k] = cyc;
      trig_in = 1'b1;
      step(9);
      trig_in = 1'b0;
      step(21);
    end
    chk("f_raw", 64'(n_raw), 64'd5);
    chk("f_dropped", 64'(n_dropped), 64'd1);
    chk("f_busy", 64'(busy), 64'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("f_valid", 64'(out_valid), 64'd1);
      chk("f_evnum", 64'(out_evnum), 64'(k));
      chk("f_ts", 64'(out_tstamp), 64'(ev[k]));
      step(1);
    end
    out_ready = 1'b0;
    chk("f_drained", 64'(out_valid), 64'd0);
    chk("f_busy_low", 64'(busy), 64'd0);

    // deadtime=0, level held 30 cycles: one record only.
    do_clr();
    deadtime = 16'd0;
    e = cyc;
    trig_in = 1'b1;
    step(30);
    trig_in = 1'b0;
    step(5);
    chk("h_raw", 64'(n_raw), 64'd1);
    chk("h_evnum", 64'(out_evnum), 64'd0);
    chk("h_ts", 64'(out_tstamp), 64'(e));
    pop_one();
    chk("h_single", 64'(out_valid), 64'd0);

    // Reset asserted in DEAD with two records buffered.
    do_clr();
    deadtime = 16'd20;
    for (int k = 0; k < 2; k++) begin
      if (k == 1) begin
        trig_in = 1'b1;
        step(9);
        trig_in = 1'b0;
      end else begin
        trig_in = 1'b1;
        step(9);
        trig_in = 1'b0;
        step(21);
      end
    end
    chk("r_pre_raw", 64'(n_raw), 64'd2);
    chk("r_pre_busy", 64'(busy), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("r_valid", 64'(out_valid), 64'd0);
    chk("r_busy", 64'(busy), 64'd0);
    chk("r_cnts", {16'd0, n_raw, n_vetoed, n_dropped}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    cyc = 0;
    step(2);
    e = cyc;
    trig_in = 1'b1;
    step(4);
    chk("r2_valid", 64'(out_valid), 64'd1);
    chk("r2_evnum", 64'(out_evnum), 64'd0);
    chk("r2_ts", 64'(out_tstamp), 64'(e));
    chk("r2_raw", 64'(n_raw), 64'd1);
    step(5);
    trig_in = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
